// File: rtl/hazard_sched_if.sv
// Hazard scheduler bus: ID-stage instruction info and branch resolution in,
// PC / pipeline-buffer enable and flush controls out.
interface hazard_sched_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_reg_write;
    logic [4:0] id_dst;
    logic       br_taken;

    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       ex_mem_flush;

    // Pipeline side: supplies instruction info, consumes controls
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_reg_write, id_dst, br_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_flush
    );

    // Scheduler side
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_reg_write, id_dst, br_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_flush
    );
endinterface

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler for a 5-stage core without forwarding.
// Tracks in-flight destinations in a 3-entry scoreboard (EX/MEM/WB),
// stalls the front end on RAW hazards and flushes on a taken branch.
module hazard_sched #(
    parameter bit          WB_BYPASS = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_sched_if.slave    bus,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_STALL = 2'b01,
        S_FLUSH = 2'b10
    } act_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
    } sb_entry_t;

    sb_entry_t sb_ex, sb_mem, sb_wb;
    sb_entry_t issue_entry;
    act_e      state_q;
    act_e      action;
    logic      rs_hit, rt_hit, hazard;

    assign state = state_q;

    // Match ID source registers against the in-flight destination window
    always_comb begin
        rs_hit = (sb_ex.valid  && (sb_ex.dst  == bus.id_rs)) ||
                 (sb_mem.valid && (sb_mem.dst == bus.id_rs)) ||
                 (!WB_BYPASS && sb_wb.valid && (sb_wb.dst == bus.id_rs));
        rt_hit = (sb_ex.valid  && (sb_ex.dst  == bus.id_rt)) ||
                 (sb_mem.valid && (sb_mem.dst == bus.id_rt)) ||
                 (!WB_BYPASS && sb_wb.valid && (sb_wb.dst == bus.id_rt));
        hazard = bus.id_valid &&
                 ((bus.id_uses_rs && (bus.id_rs != 5'd0) && rs_hit) ||
                  (bus.id_uses_rt && (bus.id_rt != 5'd0) && rt_hit));
    end

    // Choose this cycle's action: flush beats stall beats run
    always_comb begin
        if (bus.br_taken)
            action = S_FLUSH;
        else if (hazard)
            action = S_STALL;
        else
            action = S_RUN;
        issue_entry.valid = bus.id_valid && bus.id_reg_write && (bus.id_dst != 5'd0);
        issue_entry.dst   = bus.id_dst;
    end

    // Drive pipeline controls; reset forces the pipeline into a frozen, flushed state
    always_comb begin
        bus.pc_en        = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_bubble = 1'b0;
        bus.ex_mem_flush = 1'b0;
        if (!rst_n) begin
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
            bus.ex_mem_flush = 1'b1;
        end else begin
            unique case (action)
                S_FLUSH: begin
                    bus.if_id_flush  = 1'b1;
                    bus.id_ex_bubble = 1'b1;
                    bus.ex_mem_flush = 1'b1;
                end
                S_STALL: begin
                    bus.pc_en        = 1'b0;
                    bus.if_id_en     = 1'b0;
                    bus.id_ex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Scoreboard shift, recorded action and saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_ex     <= '0;
            sb_mem    <= '0;
            sb_wb     <= '0;
            state_q   <= S_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= action;
            sb_wb   <= sb_mem;
            unique case (action)
                S_FLUSH: begin
                    // instruction leaving EX is killed, so MEM gets nothing valid
                    sb_ex  <= '0;
                    sb_mem <= '0;
                    if (flush_cnt != '1)
                        flush_cnt <= flush_cnt + CNT_W'(1);
                end
                S_STALL: begin
                    sb_ex  <= '0;
                    sb_mem <= sb_ex;
                    if (stall_cnt != '1)
                        stall_cnt <= stall_cnt + CNT_W'(1);
                end
                default: begin
                    sb_ex  <= issue_entry;
                    sb_mem <= sb_ex;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: three instances share stimulus
// (WB_BYPASS=0, WB_BYPASS=1, and WB_BYPASS=0 with 2-bit counters).
module tb_hazard_sched;

    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11111;
    localparam logic [4:0] C_RST   = 5'b00111;

    typedef struct {
        logic [4:0] c0;
        logic [4:0] c1;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_sched_if bus0 ();
    hazard_sched_if bus1 ();
    hazard_sched_if bus2 ();

    logic [1:0]  state0, state1, state2;
    logic [15:0] stall0, flush0, stall1, flush1;
    logic [1:0]  stall2, flush2;
    logic [4:0]  ctl0, ctl1, ctl2;

    hazard_sched #(.WB_BYPASS(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .state(state0), .stall_cnt(stall0), .flush_cnt(flush0));
    hazard_sched #(.WB_BYPASS(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .state(state1), .stall_cnt(stall1), .flush_cnt(flush1));
    hazard_sched #(.WB_BYPASS(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .state(state2), .stall_cnt(stall2), .flush_cnt(flush2));

    assign bus1.id_valid     = bus0.id_valid;
    assign bus1.id_rs        = bus0.id_rs;
    assign bus1.id_rt        = bus0.id_rt;
    assign bus1.id_uses_rs   = bus0.id_uses_rs;
    assign bus1.id_uses_rt   = bus0.id_uses_rt;
    assign bus1.id_reg_write = bus0.id_reg_write;
    assign bus1.id_dst       = bus0.id_dst;
    assign bus1.br_taken     = bus0.br_taken;
    assign bus2.id_valid     = bus0.id_valid;
    assign bus2.id_rs        = bus0.id_rs;
    assign bus2.id_rt        = bus0.id_rt;
    assign bus2.id_uses_rs   = bus0.id_uses_rs;
    assign bus2.id_uses_rt   = bus0.id_uses_rt;
    assign bus2.id_reg_write = bus0.id_reg_write;
    assign bus2.id_dst       = bus0.id_dst;
    assign bus2.br_taken     = bus0.br_taken;

    assign ctl0 = {bus0.pc_en, bus0.if_id_en, bus0.if_id_flush, bus0.id_ex_bubble, bus0.ex_mem_flush};
    assign ctl1 = {bus1.pc_en, bus1.if_id_en, bus1.if_id_flush, bus1.id_ex_bubble, bus1.ex_mem_flush};
    assign ctl2 = {bus2.pc_en, bus2.if_id_en, bus2.if_id_flush, bus2.id_ex_bubble, bus2.ex_mem_flush};

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic rw,
                          input logic [4:0] dst, input logic br);
        bus0.id_valid     = v;
        bus0.id_rs        = rs;
        bus0.id_rt        = rt;
        bus0.id_uses_rs   = urs;
        bus0.id_uses_rt   = urt;
        bus0.id_reg_write = rw;
        bus0.id_dst       = dst;
        bus0.br_taken     = br;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
            e.c0 = C_RST; e.c1 = C_RST;
            exp_q.push_back(e);
            #2;
            e = exp_q.pop_front();
            checks++; if (ctl0 !== e.c0) begin errors++; $display("FAIL reset_ctl0 cyc %0d got %b exp %b", i, ctl0, e.c0); end
            checks++; if (ctl1 !== e.c1) begin errors++; $display("FAIL reset_ctl1 cyc %0d got %b exp %b", i, ctl1, e.c1); end
            checks++; if (ctl2 !== e.c0) begin errors++; $display("FAIL reset_ctl2 cyc %0d got %b exp %b", i, ctl2, e.c0); end
        end
        checks++; if (stall0 !== 16'd0 || flush0 !== 16'd0) begin errors++; $display("FAIL reset_cnt0 got %0d/%0d exp 0/0", stall0, flush0); end
        checks++; if (stall2 !== 2'd0 || flush2 !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got %0d/%0d exp 0/0", stall2, flush2); end
        checks++; if (state0 !== 2'b00 || state1 !== 2'b00 || state2 !== 2'b00) begin errors++; $display("FAIL reset_state got %b %b %b exp 00", state0, state1, state2); end
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        checks++; if (ctl0 !== C_RUN) begin errors++; $display("FAIL release_ctl0 got %b exp %b", ctl0, C_RUN); end
        checks++; if (ctl1 !== C_RUN) begin errors++; $display("FAIL release_ctl1 got %b exp %b", ctl1, C_RUN); end
        @(negedge clk);
        #2;
        checks++; if (state0 !== 2'b00) begin errors++; $display("FAIL release_state got %b exp 00", state0); end
    endtask

    task automatic test_load_use;
        exp_t e;
        logic [4:0] x0 [5];
        logic [4:0] x1 [5];
        x0 = '{C_RUN, C_STALL, C_STALL, C_STALL, C_RUN};
        x1 = '{C_RUN, C_STALL, C_STALL, C_RUN, C_RUN};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) set_id(1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0);
            else        set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
            e.c0 = x0[i]; e.c1 = x1[i];
            exp_q.push_back(e);
            #2;
            e = exp_q.pop_front();
            checks++; if (ctl0 !== e.c0) begin errors++; $display("FAIL load_use_ctl0 cyc %0d got %b exp %b", i, ctl0, e.c0); end
            checks++; if (ctl1 !== e.c1) begin errors++; $display("FAIL load_use_ctl1 cyc %0d got %b exp %b", i, ctl1, e.c1); end
            checks++; if (ctl2 !== e.c0) begin errors++; $display("FAIL load_use_ctl2 cyc %0d got %b exp %b", i, ctl2, e.c0); end
            if (i == 2) begin
                checks++; if (state0 !== 2'b01) begin errors++; $display("FAIL load_use_state got %b exp 01", state0); end
            end
            @(negedge clk);
        end
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        checks++; if (stall0 !== 16'd3) begin errors++; $display("FAIL load_use_cnt0 got %0d exp 3", stall0); end
        checks++; if (stall1 !== 16'd2) begin errors++; $display("FAIL load_use_cnt1 got %0d exp 2", stall1); end
        checks++; if (stall2 !== 2'd3) begin errors++; $display("FAIL load_use_cnt2 got %0d exp 3", stall2); end
    endtask

    task automatic test_zero_unused;
        exp_t e;
        logic [4:0] x0 [7];
        logic [4:0] x1 [7];
        x0 = '{C_RUN, C_RUN, C_RUN, C_RUN, C_STALL, C_STALL, C_RUN};
        x1 = '{C_RUN, C_RUN, C_RUN, C_RUN, C_STALL, C_RUN, C_RUN};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
                1: set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
                2: set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
                3: set_id(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
                default: set_id(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
            endcase
            e.c0 = x0[i]; e.c1 = x1[i];
            exp_q.push_back(e);
            #2;
            e = exp_q.pop_front();
            checks++; if (ctl0 !== e.c0) begin errors++; $display("FAIL zero_unused_ctl0 cyc %0d got %b exp %b", i, ctl0, e.c0); end
            checks++; if (ctl1 !== e.c1) begin errors++; $display("FAIL zero_unused_ctl1 cyc %0d got %b exp %b", i, ctl1, e.c1); end
            @(negedge clk);
        end
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        checks++; if (stall0 !== 16'd2 || stall1 !== 16'd1) begin errors++; $display("FAIL zero_unused_cnt got %0d/%0d exp 2/1", stall0, stall1); end
    endtask

    task automatic test_distance;
        exp_t e;
        logic [4:0] x0 [5];
        logic [4:0] x1 [5];
        x0 = '{C_RUN, C_RUN, C_STALL, C_STALL, C_RUN};
        x1 = '{C_RUN, C_RUN, C_STALL, C_RUN, C_RUN};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
            else if (i == 1) set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0);
            else             set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
            e.c0 = x0[i]; e.c1 = x1[i];
            exp_q.push_back(e);
            #2;
            e = exp_q.pop_front();
            checks++; if (ctl0 !== e.c0) begin errors++; $display("FAIL distance_ctl0 cyc %0d got %b exp %b", i, ctl0, e.c0); end
            checks++; if (ctl1 !== e.c1) begin errors++; $display("FAIL distance_ctl1 cyc %0d got %b exp %b", i, ctl1, e.c1); end
            @(negedge clk);
        end
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        checks++; if (stall0 !== 16'd2 || stall1 !== 16'd1) begin errors++; $display("FAIL distance_cnt got %0d/%0d exp 2/1", stall0, stall1); end
    endtask

    task automatic test_flush_priority;
        exp_t e;
        logic [4:0] x0 [4];
        x0 = '{C_RUN, C_FLUSH, C_FLUSH, C_RUN};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
            else        set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, (i < 3) ? 1'b1 : 1'b0);
            e.c0 = x0[i]; e.c1 = x0[i];
            exp_q.push_back(e);
            #2;
            e = exp_q.pop_front();
            checks++; if (ctl0 !== e.c0) begin errors++; $display("FAIL flush_ctl0 cyc %0d got %b exp %b", i, ctl0, e.c0); end
            checks++; if (ctl1 !== e.c1) begin errors++; $display("FAIL flush_ctl1 cyc %0d got %b exp %b", i, ctl1, e.c1); end
            if (i >= 2) begin
                checks++; if (state0 !== 2'b10) begin errors++; $display("FAIL flush_state cyc %0d got %b exp 10", i, state0); end
            end
            @(negedge clk);
        end
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #2;
        checks++; if (flush0 !== 16'd2 || flush1 !== 16'd2 || flush2 !== 2'd2) begin errors++; $display("FAIL flush_cnt got %0d/%0d/%0d exp 2", flush0, flush1, flush2); end
        checks++; if (stall0 !== 16'd0 || stall1 !== 16'd0) begin errors++; $display("FAIL flush_stall_cnt got %0d/%0d exp 0", stall0, stall1); end
        checks++; if (state0 !== 2'b00) begin errors++; $display("FAIL flush_state_end got %b exp 00", state0); end
    endtask

    task automatic test_saturate_reset;
        exp_t e;
        logic [4:0] x0 [8];
        x0 = '{C_RUN, C_STALL, C_STALL, C_STALL, C_RUN, C_STALL, C_STALL, C_STALL};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0)     set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
            else if (i < 5) set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0);
            else            set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
            e.c0 = x0[i]; e.c1 = 5'd0;
            exp_q.push_back(e);
            #2;
            e = exp_q.pop_front();
            checks++; if (ctl0 !== e.c0) begin errors++; $display("FAIL saturate_ctl0 cyc %0d got %b exp %b", i, ctl0, e.c0); end
            checks++; if (ctl2 !== e.c0) begin errors++; $display("FAIL saturate_ctl2 cyc %0d got %b exp %b", i, ctl2, e.c0); end
            if (i < 7) @(negedge clk);
        end
        checks++; if (stall0 !== 16'd5) begin errors++; $display("FAIL saturate_cnt0 got %0d exp 5", stall0); end
        checks++; if (stall2 !== 2'd3) begin errors++; $display("FAIL saturate_cnt2 got %0d exp 3", stall2); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (stall0 !== 16'd0 || stall2 !== 2'd0) begin errors++; $display("FAIL async_reset_cnt got %0d/%0d exp 0/0", stall0, stall2); end
        checks++; if (ctl0 !== C_RST) begin errors++; $display("FAIL async_reset_ctl0 got %b exp %b", ctl0, C_RST); end
        checks++; if (state0 !== 2'b00) begin errors++; $display("FAIL async_reset_state got %b exp 00", state0); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checks++; if (ctl0 !== C_RUN) begin errors++; $display("FAIL async_reset_sb_ctl0 got %b exp %b", ctl0, C_RUN); end
        checks++; if (ctl2 !== C_RUN) begin errors++; $display("FAIL async_reset_sb_ctl2 got %b exp %b", ctl2, C_RUN); end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        test_reset();
        test_load_use();
        test_zero_unused();
        test_distance();
        test_flush_priority();
        test_saturate_reset();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
        end
        checks++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hazard_sched.md
# hazard_sched

Pipeline hazard scheduler for the 5-stage IF/ID/EX/MEM/WB core. The datapath has no forwarding and resolves branches at the EX/MEM boundary, so this block sequences it. It tracks in-flight register destinations in a 3-entry scoreboard, stalls the front end on read-after-write hazards, and flushes wrong-path instructions on a taken branch. It drives the PC and pipeline-buffer enable/flush controls and exposes stall/flush statistics.

## Interface
- `WB_BYPASS`, default 0: 1 means the register file is write-through (WB write visible to an ID read in the same cycle), so the WB stage is excluded from the hazard window.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `id_valid` input, 1: the IF/ID buffer holds a real instruction.
- `id_rs` input, 5: IF/ID instr[25:21].
- `id_rt` input, 5: IF/ID instr[20:16].
- `id_uses_rs` input, 1: the ID instruction reads rs.
- `id_uses_rt` input, 1: the ID instruction reads rt (R-type, sw, beq).
- `id_reg_write` input, 1: control-unit WB[0] for the ID instruction.
- `id_dst` input, 5: destination after RegDst selection (rd or rt).
- `br_taken` input, 1: EX/MEM M[0] & ZF.
- `pc_en` output, 1: PC load enable.
- `if_id_en` output, 1: IF/ID load enable.
- `if_id_flush` output, 1: IF/ID loads a NOP.
- `id_ex_bubble` output, 1: ID/EX loads zeroed WB/M/EX controls.
- `ex_mem_flush` output, 1: EX/MEM loads zeroed WB/M controls.
- `state` output, 2: 00 RUN, 01 STALL, 10 FLUSH (action taken last cycle).
- `stall_cnt` output, CNT_W: saturating count of stall cycles.
- `flush_cnt` output, CNT_W: saturating count of flush events.

## Operation
- Scoreboard: three entries `sb_ex`, `sb_mem`, `sb_wb`, each {valid, dst[4:0]}. They shift EX→MEM→WB every cycle. The WB entry drops off after its cycle.
- Entry into `sb_ex` when ID issues (no stall, no flush): valid = id_valid & id_reg_write & (id_dst != 0), dst = id_dst. Otherwise `sb_ex` <= invalid.
- Hazard (combinational): id_valid & ((id_uses_rs & id_rs != 0 & match(id_rs)) | (id_uses_rt & id_rt != 0 & match(id_rt))).
  - match(r) tests `sb_ex` and `sb_mem`, plus `sb_wb` when WB_BYPASS=0.
  - Register 0 never hazards.
- Priority is flush > stall > run.
- FLUSH (br_taken=1): pc_en=1 (takes the branch target), if_id_flush=1, if_id_en=1, id_ex_bubble=1, ex_mem_flush=1.
  - `sb_ex` and `sb_mem` both load invalid, because the instruction leaving EX is killed.
  - `sb_wb` <= old `sb_mem` (the branch itself, normally invalid).
  - flush_cnt increments.
  - Any simultaneous hazard is ignored.
- STALL (hazard, no br_taken): pc_en=0, if_id_en=0, id_ex_bubble=1, others 0. The scoreboard shifts with an invalid `sb_ex`. stall_cnt increments.
- RUN: pc_en=1, if_id_en=1, all bubble/flush outputs 0.
- `state` register <= the action chosen in the current cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- All control outputs are combinational from the scoreboard and the current inputs, with zero-cycle latency to the buffer enables.
- Reset (rst_n low, asynchronous):
  - Scoreboard invalid, state=RUN, counters 0.
  - While rst_n is low, outputs are forced: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
- First cycle after release: empty scoreboard, so the block is in RUN unless br_taken.
- Back-to-back dependent pair (producer in EX, consumer in ID):
  - WB_BYPASS=0: stall 3 cycles.
  - WB_BYPASS=1: stall 2 cycles.
- Dependence distance 2: 2 / 1 stall cycles. Distance 3: 1 / 0.
- Stall resolves in the cycle the producer leaves the window. The consumer issues that same cycle.
- br_taken asserts for exactly one cycle per taken branch. Consecutive br_taken cycles are each handled as an independent FLUSH.
- Reset asserted mid-stall or mid-flush clears everything immediately; there is no partial counter update.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs → pc_en=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1, counters 0. After release with idle inputs → pc_en=1, state=00.
- Load-use: issue dst=2, reg_write=1, then ID rs=2, uses_rs=1. With WB_BYPASS=0 → pc_en=0 and id_ex_bubble=1 for exactly 3 cycles, then issue, stall_cnt=3. Repeat with WB_BYPASS=1 → 2 cycles, stall_cnt=2.
- Zero/unused register: producer dst=0 then consumer rs=0 → no stall. Producer dst=5 then consumer rt=5 with uses_rt=0 → no stall.
- Distance: producer, an independent instruction, then consumer of the producer's dst → 2 stall cycles (WB_BYPASS=0).
- Flush priority: hazard active and br_taken=1 in the same cycle → if_id_flush=1, ex_mem_flush=1, id_ex_bubble=1, pc_en=1, flush_cnt+1, stall_cnt unchanged, `sb_ex`/`sb_mem` cleared. Next cycle, a consumer of the killed dst → no stall.
- Saturation/reset: with CNT_W=2, force 5 stall cycles → stall_cnt=3. Assert rst_n low mid-stall → stall_cnt=0 and scoreboard empty asynchronously.
